piso_shift_transmitter: RTL and testbench

// - Parallel-in/serial-out transmitter. It is the sending end for the bidirectional serial-in/parallel-out register.
// - Accepts a WIDTH-bit word over a valid/ready load port and shifts it out one bit per accepted beat.
// - Each word is sent MSB-first or LSB-first, selected per word.
// - Drives the serial input of the receiving shift register. Optional even parity trails the data.
//

---
 rtl/piso_pkg.sv | 6 +
 rtl/piso_shift_transmitter_bit_counter.sv | 18 +
 rtl/piso_shift_transmitter.sv | 68 ++++++
 tb/tb_piso_shift_transmitter.sv | 115 +++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// piso_pkg: frame FSM states and per-word shift direction encodings.
package piso_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PARITY} state_t;
  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;
endpackage

// File: rtl/piso_shift_transmitter_bit_counter.sv
// piso_bit_counter: loadable down-counter of remaining data beats in a frame.
module piso_bit_counter #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic clr_n,
  input  logic load,
  input  logic dec,
  output logic is_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [CW-1:0] cnt;
  assign is_zero = cnt == '0;
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) cnt <= '0;
    else if (load) cnt <= CW'(WIDTH - 1);
    else if (dec && !is_zero) cnt <= cnt - 1'b1;
endmodule

// File: rtl/piso_shift_transmitter.sv
// piso_shift_transmitter: valid/ready parallel load, serial out MSB- or LSB-first per word.
// Define PARITY_EN to append an even-parity bit that carries ser_last.
module piso_shift_transmitter
  import piso_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_dir,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last
);
  state_t state, state_nx;
  logic [WIDTH-1:0] sreg;
  logic dir, is_zero, beat, accept, data_bit;
  assign beat = ser_valid && ser_ready;
  assign load_ready = state == ST_IDLE || (beat && ser_last);
  assign accept = load_valid && load_ready;
  assign ser_valid = state != ST_IDLE;
  assign data_bit = dir == DIR_MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
`ifdef PARITY_EN
  logic par;
  assign ser_out = (state == ST_SHIFT && data_bit) || (state == ST_PARITY && par);
  assign ser_last = state == ST_PARITY;
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) par <= 1'b0;
    else if (accept) par <= ^load_data;
`else
  assign ser_out = state == ST_SHIFT && data_bit;
  assign ser_last = state == ST_SHIFT && is_zero;
`endif
  always_comb begin
    state_nx = state;
    if (accept) state_nx = ST_SHIFT;
`ifdef PARITY_EN
    else if (beat && state == ST_SHIFT && is_zero) state_nx = ST_PARITY;
    else if (beat && state == ST_PARITY) state_nx = ST_IDLE;
`else
    else if (beat && state == ST_SHIFT && is_zero) state_nx = ST_IDLE;
`endif
  end
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      state <= ST_IDLE;
      sreg <= '0;
      dir <= DIR_MSB_FIRST;
    end else begin
      state <= state_nx;
      if (accept) begin
        sreg <= load_data;
        dir <= load_dir;
      end else if (beat && state == ST_SHIFT)
        sreg <= dir == DIR_MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
    end
  piso_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk(clk),
    .clr_n(clr_n),
    .load(accept),
    .dec(beat && state == ST_SHIFT),
    .is_zero(is_zero)
  );
endmodule

// File: tb/tb_piso_shift_transmitter.sv
// tb_piso_shift_transmitter: directed steps with a queue of expected serial bits.
module tb_piso_shift_transmitter;
  localparam int W = 4;
`ifdef PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  typedef struct {logic b; logic l;} sbit_t;
  logic clk = 1'b0, clr_n = 1'b0, load_valid = 1'b0, load_dir = 1'b0, ser_ready = 1'b0;
  logic load_ready, ser_out, ser_valid, ser_last;
  logic [W-1:0] load_data = '0;
  sbit_t q[$];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  piso_shift_transmitter #(.WIDTH(W)) dut (
    .clk(clk), .clr_n(clr_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_dir(load_dir), .ser_out(ser_out),
    .ser_valid(ser_valid), .ser_ready(ser_ready), .ser_last(ser_last)
  );
  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic push_word(input logic [W-1:0] d, input logic dr);
    for (int i = 0; i < W; i++) q.push_back('{dr ? d[i] : d[W-1-i], (i == W-1) && !PAR});
    if (PAR) q.push_back('{^d, 1'b1});
  endtask
  task automatic step(input logic lv, input logic [W-1:0] d, input logic dr, input logic sr);
    logic exp_lr;
    load_valid = lv; load_data = d; load_dir = dr; ser_ready = sr;
    #1;
    exp_lr = (q.size() == 0) || (sr && q[0].l);
    chk("load_ready", load_ready, exp_lr);
    if (q.size() > 0) begin
      chk("ser_valid", ser_valid, 1'b1);
      chk("ser_out", ser_out, q[0].b);
      chk("ser_last", ser_last, q[0].l);
      if (sr) void'(q.pop_front());
    end else begin
      chk("idle_valid", ser_valid, 1'b0);
      chk("idle_out", ser_out, 1'b0);
      chk("idle_last", ser_last, 1'b0);
    end
    if (lv && exp_lr) push_word(d, dr);
    @(posedge clk); #1;
  endtask
  task automatic drain();
    for (int n = 0; n < 20 && q.size() > 0; n++) step(1'b0, '0, 1'b0, 1'b1);
    chk("drained", q.size() == 0, 1'b1);
  endtask
  task automatic to_last();
    for (int n = 0; n < 20 && q.size() > 1; n++) step(1'b0, '0, 1'b0, 1'b1);
    chk("at_last", q.size() == 1, 1'b1);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 clr_n = 1'b1;
    #1;
    chk("rst_valid", ser_valid, 1'b0);
    chk("rst_out", ser_out, 1'b0);
    chk("rst_last", ser_last, 1'b0);
    chk("rst_ready", load_ready, 1'b1);
    @(posedge clk); #1;
    // MSB first, with a mid-frame load attempt that must be ignored
    step(1'b1, 4'b1011, 1'b0, 1'b1);
    step(1'b1, 4'b1111, 1'b1, 1'b1);
    drain();
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 4'b1011, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 4'b0101, 1'b0, 1'b1);
    drain();
    step(1'b0, '0, 1'b0, 1'b1);
    // backpressure on bit 2
    step(1'b1, 4'b1011, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);
    drain();
    step(1'b0, '0, 1'b0, 1'b1);
    // back-to-back words, second offered on the final beat
    step(1'b1, 4'b1011, 1'b0, 1'b1);
    to_last();
    step(1'b1, 4'b0110, 1'b0, 1'b1);
    drain();
    step(1'b0, '0, 1'b0, 1'b1);
    // stall on the final beat: next word must wait
    step(1'b1, 4'b1110, 1'b1, 1'b1);
    to_last();
    step(1'b1, 4'b0011, 1'b0, 1'b0);
    step(1'b1, 4'b1001, 1'b0, 1'b1);
    drain();
    step(1'b0, '0, 1'b0, 1'b1);
    // reset mid-frame
    step(1'b1, 4'b1011, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    clr_n = 1'b0;
    #1;
    chk("midrst_valid", ser_valid, 1'b0);
    chk("midrst_out", ser_out, 1'b0);
    chk("midrst_last", ser_last, 1'b0);
    q.delete();
    repeat (2) @(posedge clk);
    #1 clr_n = 1'b1;
    step(1'b1, 4'b0001, 1'b1, 1'b1);
    drain();
    step(1'b0, '0, 1'b0, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
